display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. All digits share one BCD-to-7-segment decoder. The decoder has a 4-bit BCD input and an active-high enable; when the enable is low it drives all segments off.
This block latches a packed BCD word and sequences one digit per refresh slot onto the decoder. It drives the active-low digit anodes, inserts an anti-ghosting blank gap, and provides leading-zero blanking and blink. It sits between the counter/datapath logic and the shared decoder plus digit drivers.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8); digit 0 is least significant.
REFRESH_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYC).
BLANK_CYC, 16, cycles at the start of each slot with all anodes off and the decoder disabled.
BLINK_LOG2, 5, blink half-period is 2^BLINK_LOG2 frames.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
digits_in  in  4*NUM_DIGITS  packed BCD; bits [4k+3:4k] = digit k.
load  in  1  single-cycle strobe; captures digits_in into the pending buffer.
lzb_en  in  1  leading-zero blanking enable (level).
blink_en  in  1  blink enable (level).
dec_in  out  4  BCD code to the shared decoder.
dec_en  out  1  decoder enable, active-high.
an_n  out  NUM_DIGITS  digit anode selects, active-low, at most one bit low.
frame_done  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset: the clock and reset are fixed as above: one clock, clk; asynchronous active-low reset, rst_n. While rst_n=0 the following hold:
  - slot counter cnt=0, digit index idx=0, frame counter fcnt=0;
  - pending and active buffers = 0, pend_valid=0;
  - an_n = all ones, dec_en=0, dec_in=0, frame_done=0.
- Output timing: all outputs are combinational functions of registered state only. There is no input-to-output combinational path.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, idx increments; after NUM_DIGITS-1, idx wraps to 0.
  - A frame is NUM_DIGITS slots.
- frame_done = 1 exactly when cnt == REFRESH_DIV-1 and idx == NUM_DIGITS-1.
- Double buffering:
  - When load=1, pending <= digits_in and pend_valid <= 1. A later load before the frame boundary overwrites pending (last one wins).
  - On the frame_done edge, if pend_valid=1 then active <= pending and pend_valid <= 0.
  - If load=1 on the frame_done edge itself, the digits_in value goes straight to active and pend_valid ends at 0.
  - The displayed value therefore never changes mid-frame.
- Digit selection: dec_in = active[4*idx+3 : 4*idx] in every cycle. It does not go to 0 while blanked.
- Leading-zero blanking:
  - Digit k is blank when lzb_en=1, k != 0, and active digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked, so a value of 0 displays "0".
  - Codes 10..15 count as non-zero for this test; they are passed through to the decoder unchanged.
- Blink:
  - blink_off = bit BLINK_LOG2 of fcnt.
  - fcnt increments on every frame_done edge and wraps naturally; width is BLINK_LOG2+1.
  - When blink_en=1 and blink_off=1, the display is dark: an_n all ones, dec_en=0.
  - Deasserting blink_en takes effect in the next cycle, regardless of phase.
- Drive rule: the digit is lit when cnt >= BLANK_CYC, the digit is not LZB-blank, and it is not blink-dark. When lit:
  - an_n = ~(1 << idx) and dec_en = 1.
  - Otherwise an_n = all ones and dec_en = 0.
- Reset mid-frame: all state clears immediately and scanning restarts at idx 0 / cnt 0 after release. Any pending load is lost.

Test Plan:
(Bench uses NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, BLINK_LOG2=1.)
1. Reset then release, no load → an_n=4'b1111 for cnt 0..1; an_n=4'b1110, dec_in=0, dec_en=1 for cnt 2..7. Digit 0 shows "0", digits 1..3 show "0" with lzb_en=0. First frame_done pulse at cycle 31 after release.
2. load with digits_in=16'h1234 mid-frame → display stays 0000 until the frame_done edge. Next frame: dec_in = 4,3,2,1 in idx 0..3, with an_n 1110, 1101, 1011, 0111 in turn.
3. lzb_en=1, active=16'h0045 → idx 2 and 3 slots fully dark (an_n=1111, dec_en=0); idx 0 and 1 lit with 5 and 4. With active=16'h0000, only idx 0 is lit, showing 0.
4. Two loads, 16'hAAAA then 16'h0909, within one frame, plus a load of 16'h7777 on the frame_done edge → next frame shows 7777. pend_valid is 0 afterwards and the frame after also shows 7777.
5. blink_en=1 → frames 0–1 lit, frames 2–3 dark (an_n=1111, dec_en=0), frames 4–5 lit, repeating. Clearing blink_en during a dark frame relights the display on the next cycle.
6. Assert rst_n=0 during idx=2, cnt=5 with a pending load → outputs go to the reset values asynchronously, before the next clock edge. After release, scanning restarts at idx 0 showing 0000, and the pending value is never displayed.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Sequences one digit per refresh slot onto a shared decoder with blanking and blink.
module display_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 16,
   parameter int BLINK_LOG2  = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   input  logic                    lzb_en,
   input  logic                    blink_en,
   output logic [3:0]              dec_in,
   output logic                    dec_en,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DW     = 4 * NUM_DIGITS;
   localparam int FCNT_W = BLINK_LOG2 + 1;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
   logic [DW-1:0]         pend_q, pend_d;
   logic [DW-1:0]         act_q, act_d;
   logic                  pend_valid_q, pend_valid_d;
   logic                  lzb_en_q, blink_en_q;
   logic                  slot_end;
   logic                  all_zero;
   logic                  cur_blank;
   logic                  lit;
   logic [NUM_DIGITS-1:0] lzb_blank;

   assign slot_end   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
   assign frame_done = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

   // NOTE: each always_comb assigns every output a default first, so no latch is inferred.
   always_comb begin
      cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
      idx_d  = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      fcnt_d = frame_done ? fcnt_q + 1'b1 : fcnt_q;
   end

   // Active only changes on the frame boundary; a load on that same edge bypasses pending.
   always_comb begin
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      act_d        = act_q;
      if (load) begin
         pend_d       = digits_in;
         pend_valid_d = 1'b1;
      end
      if (frame_done) begin
         if (load) begin
            act_d = digits_in;
         end else if (pend_valid_q) begin
            act_d = pend_q;
         end
         pend_valid_d = 1'b0;
      end
   end

   // A digit is leading-zero blank when it and every more significant digit are zero.
   always_comb begin
      all_zero  = 1'b1;
      lzb_blank = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         all_zero     = all_zero && (act_q[4*k +: 4] == 4'd0);
         lzb_blank[k] = lzb_en_q && all_zero;
      end
   end

   always_comb begin
      dec_in    = '0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            dec_in    = act_q[4*k +: 4];
            cur_blank = lzb_blank[k];
         end
      end
      lit    = (cnt_q >= CNT_W'(BLANK_CYC)) && !cur_blank
               && !(blink_en_q && fcnt_q[BLINK_LOG2]);
      dec_en = lit;
      an_n   = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the digit buffers are ordinary flops, so they clear with the rest of the state on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         fcnt_q       <= '0;
         pend_q       <= '0;
         act_q        <= '0;
         pend_valid_q <= 1'b0;
         lzb_en_q     <= 1'b0;
         blink_en_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         fcnt_q       <= fcnt_d;
         pend_q       <= pend_d;
         act_q        <= act_d;
         pend_valid_q <= pend_valid_d;
         lzb_en_q     <= lzb_en;
         blink_en_q   <= blink_en;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus queues per-cycle expectations,
// a monitor compares them at each falling clock edge and on reset assertion.
module tb_display_scan_ctrl;

   localparam int ND = 4;

   typedef struct {
      int         n;
      logic [3:0] an_n;
      logic       dec_en;
      logic [3:0] dec_in;
      logic       fd;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [15:0]   digits_in = '0;
   logic          load = 1'b0;
   logic          lzb_en = 1'b0;
   logic          blink_en = 1'b0;
   logic [3:0]    dec_in;
   logic          dec_en;
   logic [ND-1:0] an_n;
   logic          frame_done;

   exp_t sb_q[$];
   exp_t rst_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pos_cnt = 0;

   display_scan_ctrl #(
      .NUM_DIGITS (ND),
      .REFRESH_DIV(8),
      .BLANK_CYC  (2),
      .BLINK_LOG2 (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .digits_in (digits_in),
      .load      (load),
      .lzb_en    (lzb_en),
      .blink_en  (blink_en),
      .dec_in    (dec_in),
      .dec_en    (dec_en),
      .an_n      (an_n),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Sample index: number of rising edges since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pos_cnt <= 0;
      else        pos_cnt <= pos_cnt + 1;
   end

   task automatic compare(input string name, input int n, input exp_t e);
      logic [9:0] got, want;
      got  = {an_n, dec_en, dec_in, frame_done};
      want = {e.an_n, e.dec_en, e.dec_in, e.fd};
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s n=%0d got an_n=%b dec_en=%b dec_in=%h fd=%b want an_n=%b dec_en=%b dec_in=%h fd=%b",
                  name, n, an_n, dec_en, dec_in, frame_done, e.an_n, e.dec_en, e.dec_in, e.fd);
      end
   endtask

   // Monitor: pops reset expectations on reset assertion, cycle expectations at each negedge.
   initial begin
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            if (rst_q.size() > 0) begin
               exp_t e;
               #1;
               e = rst_q.pop_front();
               compare("reset", -1, e);
            end
         end else begin
            while (sb_q.size() > 0 && sb_q[0].n < pos_cnt) begin
               n_cmp++;
               n_bad++;
               $display("FAIL missed_sample n=%0d got sample=%0d want sample=%0d", sb_q[0].n, pos_cnt, sb_q[0].n);
               void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].n == pos_cnt) begin
               exp_t e;
               e = sb_q.pop_front();
               compare("scan", e.n, e);
            end
         end
      end
   end

   // Expected outputs of one 32-cycle frame: value shown, per-digit lit mask,
   // forced-dark up to sample dark_until, entries up to frame offset last.
   task automatic expect_frame(input int f, input logic [15:0] val, input logic [3:0] mask,
                               input int dark_until, input int last);
      for (int i = 0; i <= last; i++) begin
         exp_t e;
         int   idx;
         int   c;
         logic lt;
         idx      = i / 8;
         c        = i % 8;
         e.n      = 32 * f + i;
         lt       = (c >= 2) && mask[idx] && (e.n > dark_until);
         e.an_n   = lt ? ~(4'b0001 << idx) : 4'b1111;
         e.dec_en = lt;
         e.dec_in = val[4*idx +: 4];
         e.fd     = (i == 31);
         sb_q.push_back(e);
      end
   endtask

   task automatic push_reset_exp();
      exp_t e;
      e.n = -1; e.an_n = 4'b1111; e.dec_en = 1'b0; e.dec_in = 4'h0; e.fd = 1'b0;
      rst_q.push_back(e);
   endtask

   task automatic at_sample(input int k);
      int guard;
      guard = 0;
      @(negedge clk);
      while (pos_cnt < k && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (pos_cnt != k) begin
         n_bad++;
         $display("FAIL sync got sample=%0d want sample=%0d", pos_cnt, k);
      end
   endtask

   task automatic do_load(input int k, input logic [15:0] v);
      at_sample(k);
      digits_in = v;
      load      = 1'b1;
      at_sample(k + 1);
      load      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got time=%0t want finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, release just after a rising edge.
      push_reset_exp();
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      expect_frame(0, 16'h0000, 4'b1111, -1, 31);
      #2 rst_n = 1'b1;

      // Mid-frame load is held back until the frame boundary.
      do_load(10, 16'h1234);
      expect_frame(1, 16'h1234, 4'b1111, -1, 31);

      // Leading-zero blanking on 0045, then on 0000.
      do_load(40, 16'h0045);
      expect_frame(2, 16'h0045, 4'b0011, -1, 31);
      at_sample(63);
      lzb_en = 1'b1;
      expect_frame(3, 16'h0000, 4'b0001, -1, 31);
      do_load(70, 16'h0000);

      // Two loads in one frame, then a load on the frame_done edge wins.
      do_load(100, 16'hAAAA);
      do_load(110, 16'h0909);
      expect_frame(4, 16'h7777, 4'b1111, -1, 31);
      expect_frame(5, 16'h7777, 4'b1111, -1, 31);
      at_sample(127);
      lzb_en    = 1'b0;
      digits_in = 16'h7777;
      load      = 1'b1;
      at_sample(128);
      load      = 1'b0;

      // Blink: frame counter phases 2,3 are dark; clearing blink_en relights at once.
      at_sample(175);
      blink_en = 1'b1;
      expect_frame(6, 16'h7777, 4'b1111, 255, 31);
      expect_frame(7, 16'h7777, 4'b1111, 255, 31);
      expect_frame(8, 16'h7777, 4'b1111, -1, 31);
      expect_frame(9, 16'h7777, 4'b1111, -1, 31);
      expect_frame(10, 16'h7777, 4'b1111, 332, 31);
      at_sample(332);
      blink_en = 1'b0;

      // Reset at idx 2 / cnt 5 with a pending load.
      expect_frame(11, 16'h7777, 4'b1111, -1, 21);
      do_load(355, 16'h5555);
      at_sample(373);
      push_reset_exp();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      expect_frame(0, 16'h0000, 4'b1111, -1, 31);
      expect_frame(1, 16'h0000, 4'b1111, -1, 31);
      #2 rst_n = 1'b1;
      at_sample(64);

      n_cmp++;
      if (sb_q.size() != 0 || rst_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got pending=%0d want pending=0", sb_q.size() + rst_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
